// File: rtl/serial_alu_pkg.sv
// serial_alu_pkg
//   Shared definitions for the bit-serial ALU responder: op codes and the
//   FSM state encoding. Imported by serial_alu_bit_slice and
//   serial_alu_responder.
package serial_alu_pkg;

    typedef enum logic [1:0] {
        OP_ZERO = 2'd0,
        OP_ADD  = 2'd1,
        OP_XOR  = 2'd2,
        OP_LT   = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

endpackage

// File: rtl/serial_alu_bit_slice.sv
// serial_alu_bit_slice
//   Combinational one-bit ALU step used by the serial responder.
// Ports
//   op      in   op_t  operation being performed
//   x_i     in   1     current bit of operand x
//   y_i     in   1     current bit of operand y
//   c_in    in   1     running ADD carry
//   lt_in   in   1     running LT verdict (from lower bits)
//   r_i     out  1     result bit for this position
//   c_out   out  1     next ADD carry (0 for other ops)
//   lt_out  out  1     next LT verdict
module serial_alu_bit_slice
    import serial_alu_pkg::*;
(
    input  op_t  op,
    input  logic x_i,
    input  logic y_i,
    input  logic c_in,
    input  logic lt_in,
    output logic r_i,
    output logic c_out,
    output logic lt_out
);

    // Walking LSB-first, a higher bit that differs overrides the lower verdict;
    // equal bits keep it.
    assign lt_out = (~x_i & y_i) | (~(x_i ^ y_i) & lt_in);

    always_comb begin
        r_i   = 1'b0;
        c_out = 1'b0;
        case (op)
            OP_ADD: begin
                r_i   = x_i ^ y_i ^ c_in;
                c_out = (x_i & y_i) | (x_i & c_in) | (y_i & c_in);
            end
            OP_XOR:  r_i = x_i ^ y_i;
            default: r_i = 1'b0;
        endcase
    end

endmodule

// File: rtl/serial_alu_responder.sv
// serial_alu_responder
//   Bit-serial ALU responder: accepts one (select, x, y) request on a
//   valid/ready port, processes it LSB-first one bit per clock, and returns
//   the result on a valid/ready response port.
//   Optional macro SERIAL_ALU_FLAGS_EN adds registered rsp_carry / rsp_zero.
//
//   state    | meaning
//   ST_IDLE  | ready for a request
//   ST_SHIFT | processing bit cnt of the latched operands
//   ST_RESP  | result presented, waiting for rsp_ready
// Ports
//   clk, rst               clock, synchronous active-high reset
//   req_valid/req_ready    request handshake
//   req_select, req_x/y    op code and unsigned operands
//   rsp_valid/rsp_ready    response handshake
//   rsp_z                  result
//   rsp_carry, rsp_zero    (flags build only) ADD carry-out, result==0
module serial_alu_responder
    import serial_alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_select,
    input  logic [WIDTH-1:0] req_x,
    input  logic [WIDTH-1:0] req_y,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_z
`ifdef SERIAL_ALU_FLAGS_EN
    ,
    output logic             rsp_carry,
    output logic             rsp_zero
`endif
);

    localparam int CNTW = $clog2(WIDTH) + 1;
    localparam logic [CNTW-1:0] LAST_BIT = CNTW'(WIDTH - 1);

    state_t           state, state_nxt;
    op_t              op_q;
    logic [WIDTH-1:0] x_sr, y_sr, z_q, z_nxt;
    logic [CNTW-1:0]  cnt;
    logic             carry_q, lt_q;
    logic             r_bit, c_nxt, lt_nxt;
    logic             accept;

    serial_alu_bit_slice u_slice (
        .op     (op_q),
        .x_i    (x_sr[0]),
        .y_i    (y_sr[0]),
        .c_in   (carry_q),
        .lt_in  (lt_q),
        .r_i    (r_bit),
        .c_out  (c_nxt),
        .lt_out (lt_nxt)
    );

    assign req_ready = (state == ST_IDLE) && !rst;
    assign rsp_valid = (state == ST_RESP);
    assign rsp_z     = z_q;
    assign accept    = req_valid && req_ready;

    // LT leaves only its verdict in bit 0; the others shift in from the MSB.
    always_comb begin
        z_nxt = {r_bit, z_q[WIDTH-1:1]};
        if (op_q == OP_LT) begin
            z_nxt = {{(WIDTH-1){1'b0}}, lt_nxt};
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (accept) state_nxt = ST_SHIFT;
            ST_SHIFT: if (cnt == LAST_BIT) state_nxt = ST_RESP;
            ST_RESP:  if (rsp_ready) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            op_q    <= OP_ZERO;
            x_sr    <= '0;
            y_sr    <= '0;
            z_q     <= '0;
            cnt     <= '0;
            carry_q <= 1'b0;
            lt_q    <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q    <= op_t'(req_select);
                x_sr    <= req_x;
                y_sr    <= req_y;
                cnt     <= '0;
                carry_q <= 1'b0;
                lt_q    <= 1'b0;
            end else if (state == ST_SHIFT) begin
                x_sr    <= x_sr >> 1;
                y_sr    <= y_sr >> 1;
                cnt     <= cnt + 1'b1;
                carry_q <= c_nxt;
                lt_q    <= lt_nxt;
                z_q     <= z_nxt;
            end
        end
    end

`ifdef SERIAL_ALU_FLAGS_EN
    logic zero_q;

    // carry_q only ever moves for ADD, so it already reads 0 for other ops.
    assign rsp_carry = carry_q;
    assign rsp_zero  = zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
        end else if (accept) begin
            zero_q <= 1'b0;
        end else if (state == ST_SHIFT && cnt == LAST_BIT) begin
            zero_q <= (z_nxt == '0);
        end
    end
`endif

endmodule

// File: tb/tb_serial_alu_responder.sv
module tb_serial_alu_responder;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic             req_valid;
    logic             req_ready;
    logic [1:0]       req_select;
    logic [WIDTH-1:0] req_x, req_y;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_z;
`ifdef SERIAL_ALU_FLAGS_EN
    logic             rsp_carry, rsp_zero;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_alu_responder #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_select (req_select),
        .req_x      (req_x),
        .req_y      (req_y),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_z      (rsp_z)
`ifdef SERIAL_ALU_FLAGS_EN
        ,
        .rsp_carry  (rsp_carry),
        .rsp_zero   (rsp_zero)
`endif
    );

    typedef struct {
        logic [1:0]       sel;
        logic [WIDTH-1:0] x;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] ez;
        logic             ec;
        int               hold;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic on the whole operands.
    function automatic void ref_alu(input logic [1:0] sel, input int unsigned x, input int unsigned y,
                                    output logic [WIDTH-1:0] z, output logic c);
        int unsigned s;
        z = '0;
        c = 1'b0;
        case (sel)
            2'd1: begin
                s = x + y;
                z = WIDTH'(s % (1 << WIDTH));
                c = (s >= (1 << WIDTH));
            end
            2'd2: z = WIDTH'(x ^ y);
            2'd3: z = (x < y) ? WIDTH'(1) : WIDTH'(0);
            default: z = '0;
        endcase
    endfunction

    task automatic issue(input string tag, input logic [1:0] sel, input logic [WIDTH-1:0] x,
                         input logic [WIDTH-1:0] y, input logic [WIDTH-1:0] ez, input logic ec,
                         input int hold);
        int n;
        @(negedge clk);
        req_select = sel;
        req_x      = x;
        req_y      = y;
        req_valid  = 1'b1;
        rsp_ready  = (hold == 0);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check({tag, " accept_timeout"}, 0, 1);
            req_valid = 1'b0;
            return;
        end
        @(negedge clk);
        // Scramble inputs after acceptance; they must be ignored.
        req_valid  = 1'b0;
        req_x      = WIDTH'($urandom);
        req_y      = WIDTH'($urandom);
        req_select = 2'($urandom);
        n = 1;
        while (!rsp_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, " latency"}, n, WIDTH + 1);
        if (!rsp_valid) return;
        check({tag, " z"}, rsp_z, ez);
`ifdef SERIAL_ALU_FLAGS_EN
        check({tag, " carry"}, rsp_carry, ec);
        check({tag, " zero"}, rsp_zero, (ez == 0));
`endif
        if (hold > 0) req_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check({tag, " hold_valid"}, rsp_valid, 1);
            check({tag, " hold_z"}, rsp_z, ez);
            check({tag, " hold_req_ready"}, req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        check({tag, " rsp_done"}, rsp_valid, 0);
        check({tag, " back_idle"}, req_ready, 1);
        req_valid = 1'b0;
    endtask

    vec_t vecs[$];

    initial begin
        logic [WIDTH-1:0] mz;
        logic             mc;
        logic [1:0]       rs;
        logic [WIDTH-1:0] rx, ry;

        vecs.push_back('{2'd1, 8'd6,   8'd8,   8'd14,  1'b0, 0});
        vecs.push_back('{2'd2, 8'hA5,  8'h0F,  8'hAA,  1'b0, 0});
        vecs.push_back('{2'd0, 8'hFF,  8'hFF,  8'h00,  1'b0, 0});
        vecs.push_back('{2'd1, 8'd200, 8'd100, 8'd44,  1'b1, 0});
        vecs.push_back('{2'd3, 8'd3,   8'd7,   8'd1,   1'b0, 0});
        vecs.push_back('{2'd3, 8'd7,   8'd7,   8'd0,   1'b0, 0});
        vecs.push_back('{2'd3, 8'd9,   8'd4,   8'd0,   1'b0, 0});
        vecs.push_back('{2'd3, 8'd0,   8'd255, 8'd1,   1'b0, 0});
        vecs.push_back('{2'd1, 8'd255, 8'd1,   8'd0,   1'b1, 0});
        vecs.push_back('{2'd2, 8'h3C,  8'h3C,  8'h00,  1'b0, 0});
        vecs.push_back('{2'd1, 8'd17,  8'd34,  8'd51,  1'b0, 5});

        rst        = 1'b1;
        req_valid  = 1'b0;
        req_select = 2'd0;
        req_x      = '0;
        req_y      = '0;
        rsp_ready  = 1'b0;
        repeat (3) @(negedge clk);
        check("reset rsp_valid", rsp_valid, 0);
        check("reset rsp_z", rsp_z, 0);
        check("reset req_ready", req_ready, 0);
`ifdef SERIAL_ALU_FLAGS_EN
        check("reset carry", rsp_carry, 0);
        check("reset zero", rsp_zero, 0);
`endif
        rst = 1'b0;
        @(negedge clk);
        check("post_reset req_ready", req_ready, 1);

        foreach (vecs[i]) begin
            issue($sformatf("vec%0d", i), vecs[i].sel, vecs[i].x, vecs[i].y,
                  vecs[i].ez, vecs[i].ec, vecs[i].hold);
        end

        // Reset during the 4th SHIFT cycle.
        @(negedge clk);
        req_select = 2'd1;
        req_x      = 8'hFF;
        req_y      = 8'h01;
        req_valid  = 1'b1;
        rsp_ready  = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst rsp_valid", rsp_valid, 0);
        check("midrst rsp_z", rsp_z, 0);
        check("midrst req_ready", req_ready, 0);
        rst = 1'b0;
        @(negedge clk);
        check("midrst release req_ready", req_ready, 1);
        check("midrst still_idle", rsp_valid, 0);
        issue("after_rst add", 2'd1, 8'd4, 8'd5, 8'd9, 1'b0, 0);

        for (int k = 0; k < 30; k++) begin
            rs = 2'($urandom);
            rx = WIDTH'($urandom);
            ry = WIDTH'($urandom);
            if (k % 5 == 0) ry = rx;
            ref_alu(rs, rx, ry, mz, mc);
            issue($sformatf("rand%0d", k), rs, rx, ry, mz, mc, int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
